// File: rtl/corr_pkg.sv
// corr_pkg: shared definitions for the ctrl_corrimiento shift-register sequencer.
//   - default datapath / shift-count widths
//   - FSM state encoding (3-bit)
//   - datapath control encodings
//   - saturating 16-bit increment helper for the optional statistics counters
package corr_pkg;

  localparam int CORR_WIDTH = 8;
  localparam int CORR_CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_CAPT  = 3'd3,
    ST_RESP  = 3'd4,
    ST_CLEAR = 3'd5
  } corr_state_e;

  localparam logic CORR_LOAD  = 1'b0;
  localparam logic CORR_SHIFT = 1'b1;

  function automatic logic [15:0] corr_sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/corr_contador.sv
// corr_contador: loadable down-counter used as the shift-cycle timer.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset (count clears to 0)
//   load       - load load_val (has priority over dec)
//   dec        - decrement by one; holds at zero
//   load_val   - value loaded on load
//   count      - current count
//   is_one     - terminal-count flag (count == 1)
module corr_contador
  import corr_pkg::*;
#(
  parameter int CNT_W = CORR_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             is_one
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign is_one = (count == CNT_W'(1));

endmodule

// File: rtl/ctrl_corrimiento.sv
// ctrl_corrimiento: sequencer for an 8-bit parallel-load shift-register
// datapath. Accepts one (operand, shift count) request, loads the operand,
// issues exactly N shift cycles, captures the datapath output and returns it.
// Ports:
//   clk, rst                      - clock, asynchronous active-high reset
//   req_valid/req_ready/req_data/req_shifts - request handshake
//   abort                         - cancel the transaction in flight
//   res_valid/res_ready/res_data  - response handshake
//   busy                          - controller not idle
//   sr_control/sr_data_in/sr_rst/sr_data_out - shift-register datapath side
//   txn_count/abort_count         - only with CTRL_CORRIMIENTO_STATS_EN defined
// Optional feature macro: CTRL_CORRIMIENTO_STATS_EN (saturating statistics).
//
// state | meaning
// IDLE  | ready for a request
// LOAD  | datapath loads the latched operand
// SHIFT | one shift per cycle, N cycles
// CAPT  | datapath output captured into res_data
// RESP  | result offered until res_ready
// CLEAR | one-cycle datapath clear after abort
module ctrl_corrimiento
  import corr_pkg::*;
#(
  parameter int WIDTH = CORR_WIDTH,
  parameter int CNT_W = CORR_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic [CNT_W-1:0] req_shifts,
  input  logic             abort,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             busy,
  output logic             sr_control,
  output logic [WIDTH-1:0] sr_data_in,
  output logic             sr_rst,
  input  logic [WIDTH-1:0] sr_data_out
`ifdef CTRL_CORRIMIENTO_STATS_EN
  ,
  output logic [15:0]      txn_count,
  output logic [15:0]      abort_count
`endif
);

  corr_state_e      state, state_nx;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_is_one;
  logic             accept;

  assign accept = (state == ST_IDLE) && req_valid;

  corr_contador #(.CNT_W(CNT_W)) u_contador (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .dec      (state == ST_SHIFT),
    .load_val (req_shifts),
    .count    (cnt_val),
    .is_one   (cnt_is_one)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (req_valid) state_nx = ST_LOAD;
      // The counter still holds N during LOAD, so a zero count skips SHIFT.
      ST_LOAD:  if (abort)                state_nx = ST_CLEAR;
                else if (cnt_val != '0)   state_nx = ST_SHIFT;
                else                      state_nx = ST_CAPT;
      ST_SHIFT: if (abort)                state_nx = ST_CLEAR;
                else if (cnt_is_one)      state_nx = ST_CAPT;
      ST_CAPT:  if (abort)                state_nx = ST_CLEAR;
                else                      state_nx = ST_RESP;
      ST_RESP:  if (abort)                state_nx = ST_CLEAR;
                else if (res_ready)       state_nx = ST_IDLE;
      ST_CLEAR: state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == ST_IDLE);
    busy       = (state != ST_IDLE);
    sr_control = (state == ST_SHIFT) ? CORR_SHIFT : CORR_LOAD;
    sr_rst     = (state == ST_CLEAR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_data_in <= '0;
      res_data   <= '0;
      res_valid  <= 1'b0;
    end else begin
      if (accept) sr_data_in <= req_data;
      if ((state == ST_CAPT) && !abort) begin
        res_data  <= sr_data_out;
        res_valid <= 1'b1;
      end
      // Abort or handshake both retire the result; abort drops it undelivered.
      if ((state == ST_RESP) && (abort || res_ready)) res_valid <= 1'b0;
    end
  end

`ifdef CTRL_CORRIMIENTO_STATS_EN
  logic [15:0] txn_q, abort_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txn_q   <= 16'd0;
      abort_q <= 16'd0;
    end else begin
      if ((state == ST_RESP) && res_ready && !abort) txn_q <= corr_sat_inc(txn_q);
      if ((state != ST_CLEAR) && (state_nx == ST_CLEAR)) abort_q <= corr_sat_inc(abort_q);
    end
  end

  assign txn_count   = txn_q;
  assign abort_count = abort_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_ctrl_corrimiento.sv
// Self-checking bench for ctrl_corrimiento. A behavioural shift-register
// datapath (shift left, zero fill, load on control=0) is attached to the DUT;
// expected results come from operand << N truncated to 8 bits.
// Latency is counted with the accepting edge as edge 1.
module tb_ctrl_corrimiento;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready;
  logic [7:0] req_data;
  logic [3:0] req_shifts;
  logic       abort;
  logic       res_valid, res_ready;
  logic [7:0] res_data;
  logic       busy, sr_control, sr_rst;
  logic [7:0] sr_data_in, sr_data_out;
`ifdef CTRL_CORRIMIENTO_STATS_EN
  logic [15:0] txn_count, abort_count;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int exp_txn  = 0;
  int exp_abort = 0;

  always #5 clk = ~clk;

  ctrl_corrimiento dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_data    (req_data),
    .req_shifts  (req_shifts),
    .abort       (abort),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .busy        (busy),
    .sr_control  (sr_control),
    .sr_data_in  (sr_data_in),
    .sr_rst      (sr_rst),
    .sr_data_out (sr_data_out)
`ifdef CTRL_CORRIMIENTO_STATS_EN
    ,
    .txn_count   (txn_count),
    .abort_count (abort_count)
`endif
  );

  logic [7:0] dp_q;
  always @(posedge clk or posedge rst) begin
    if (rst)             dp_q <= 8'h00;
    else if (sr_rst)     dp_q <= 8'h00;
    else if (sr_control) dp_q <= {dp_q[6:0], 1'b0};
    else                 dp_q <= sr_data_in;
  end
  assign sr_data_out = dp_q;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [3:0] n);
    int v;
    v = int'(d);
    for (int i = 0; i < int'(n); i++) v = v * 2;
    return 8'(v % 256);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_req(input logic [7:0] d, input logic [3:0] n);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_data   = d;
    req_shifts = n;
    step();
    req_valid  = 1'b0;
    req_data   = 8'($urandom);
    req_shifts = 4'($urandom);
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("sr_data_in_latched", 32'(sr_data_in), 32'(d));
  endtask

  task automatic wait_res(output int edges, output int shifts);
    edges  = 1;
    shifts = 0;
    while (!res_valid && edges < 40) begin
      if (sr_control) shifts++;
      step();
      edges++;
    end
  endtask

  task automatic do_txn(input logic [7:0] d, input logic [3:0] n, input int hold);
    int edges, shifts;
    logic [7:0] e;
    e = ref_shift(d, n);
    accept_req(d, n);
    wait_res(edges, shifts);
    chk("latency", 32'(edges), 32'(n) + 32'd3);
    chk("shift_cycles", 32'(shifts), 32'(n));
    chk("res_data", 32'(res_data), 32'(e));
    for (int i = 0; i < hold; i++) begin
      step();
      chk("res_valid_hold", 32'(res_valid), 32'd1);
      chk("res_data_hold", 32'(res_data), 32'(e));
      chk("req_ready_resp", 32'(req_ready), 32'd0);
    end
    chk("sr_data_in_held", 32'(sr_data_in), 32'(d));
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    exp_txn++;
    chk("res_valid_after_hs", 32'(res_valid), 32'd0);
    chk("req_ready_after_hs", 32'(req_ready), 32'd1);
  endtask

  initial begin
    int edges, shifts;
    rst = 1'b1; req_valid = 1'b0; req_data = 8'h00; req_shifts = 4'h0;
    abort = 1'b0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    step();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sr_control", 32'(sr_control), 32'd0);
    chk("rst_sr_rst", 32'(sr_rst), 32'd0);
    chk("rst_sr_data_in", 32'(sr_data_in), 32'd0);

    // Directed transactions: basic, N=0, N=15 with stalled consumer.
    do_txn(8'h0F, 4'd3, 0);
    do_txn(8'hA5, 4'd0, 0);
    do_txn(8'h01, 4'd15, 5);

    // Abort during the second SHIFT cycle.
    accept_req(8'hC3, 4'd4);
    step();
    chk("shift1_ctrl", 32'(sr_control), 32'd1);
    step();
    chk("shift2_ctrl", 32'(sr_control), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    exp_abort++;
    chk("clear_sr_rst", 32'(sr_rst), 32'd1);
    chk("clear_sr_control", 32'(sr_control), 32'd0);
    chk("clear_res_valid", 32'(res_valid), 32'd0);
    step();
    chk("idle_after_clear", 32'(busy), 32'd0);
    chk("sr_rst_one_cycle", 32'(sr_rst), 32'd0);
    chk("ready_after_clear", 32'(req_ready), 32'd1);
    repeat (4) begin
      step();
      chk("no_res_after_abort", 32'(res_valid), 32'd0);
    end

    // Abort is ignored in IDLE.
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_idle_busy", 32'(busy), 32'd0);
    chk("abort_idle_sr_rst", 32'(sr_rst), 32'd0);

    // Abort in CAPT (N=0) suppresses the result.
    accept_req(8'h5A, 4'd0);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    exp_abort++;
    chk("abort_capt_res_valid", 32'(res_valid), 32'd0);
    chk("abort_capt_sr_rst", 32'(sr_rst), 32'd1);
    step();

    // Abort together with res_ready in RESP: abort wins.
    accept_req(8'h3C, 4'd2);
    wait_res(edges, shifts);
    chk("resp_reached", 32'(res_valid), 32'd1);
    abort = 1'b1;
    res_ready = 1'b1;
    step();
    abort = 1'b0;
    res_ready = 1'b0;
    exp_abort++;
    chk("abort_resp_res_valid", 32'(res_valid), 32'd0);
    chk("abort_resp_sr_rst", 32'(sr_rst), 32'd1);
    step();
    chk("abort_resp_idle", 32'(req_ready), 32'd1);

    // Asynchronous reset in the middle of SHIFT.
    accept_req(8'hFF, 4'd10);
    step();
    step();
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_sr_control", 32'(sr_control), 32'd0);
    chk("arst_res_valid", 32'(res_valid), 32'd0);
    chk("arst_res_data", 32'(res_data), 32'd0);
    chk("arst_sr_data_in", 32'(sr_data_in), 32'd0);
    chk("arst_sr_rst", 32'(sr_rst), 32'd0);
    #3 rst = 1'b0;
`ifdef CTRL_CORRIMIENTO_STATS_EN
    exp_txn = 0;
    exp_abort = 0;
`endif
    step();
    do_txn(8'h03, 4'd1, 0);

    // Randomized transactions against the arithmetic reference.
    for (int k = 0; k < 10; k++) begin
      do_txn(8'($urandom), 4'($urandom), int'($urandom_range(0, 3)));
    end

`ifdef CTRL_CORRIMIENTO_STATS_EN
    accept_req(8'h11, 4'd1);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    exp_abort++;
    step();
    chk("txn_count", 32'(txn_count), 32'(exp_txn));
    chk("abort_count", 32'(abort_count), 32'(exp_abort));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
